// File: rtl/system_types_pkg.sv
// rtl/system_types_pkg.sv - shared system message, routing state and payload types for the node router
package system_types;

    typedef enum logic [3:0] {
        INIT                      = 4'd0,
        I_GENERATE_PARENT_REQUEST = 4'd1,
        I_WAIT_PARENT_ACK         = 4'd2,
        I_GENERATE_JOIN_REQUEST   = 4'd3,
        I_WAIT_JOIN_ACK           = 4'd4,
        S_GENERATE_PARENT_REQUEST = 4'd5,
        S_WAIT_PARENT_ACK         = 4'd6,
        S_GENERATE_JOIN_REQUEST   = 4'd7,
        S_WAIT_JOIN_ACK           = 4'd8,
        NORMAL                    = 4'd9,
        FATAL_ERROR               = 4'd10
    } routing_state_t;

    typedef enum logic [7:0] {
        S_NONE           = 8'h00,
        S_PARENT_REQUEST = 8'h01,
        S_PARENT_ACK     = 8'h02,
        S_JOIN_REQUEST   = 8'h03,
        S_JOIN_ACK       = 8'h04,
        S_RESET          = 8'h05,
        S_HEARTBEAT      = 8'h06
    } system_header_t;

    typedef logic [7:0]  node_id_t;
    typedef logic [63:0] system_payload_t;

    typedef struct packed {
        logic [62:0] rsvd;
        logic        is_init;
    } parent_request_t;

    typedef struct packed {
        logic [46:0] rsvd;
        logic        is_init;
        node_id_t    parent_id;
        node_id_t    child_id;
    } parent_ack_t;

    typedef struct packed {
        logic [46:0] rsvd;
        logic        is_init;
        node_id_t    parent_id;
        node_id_t    child_id;
    } join_request_t;

    typedef struct packed {
        logic [38:0] rsvd;
        logic        is_init;
        node_id_t    cur_id;
        node_id_t    parent_id;
        node_id_t    child_id;
    } join_ack_t;

    localparam int ROUTING_DEFAULT_TIMEOUT   = 1024;
    localparam int ROUTING_DEFAULT_MAX_RETRY = 3;
    localparam int ROUTING_DEFAULT_HEARTBEAT = 256;

    // I_ states belong to the initial join; S_ states to a re-join after separation.
    function automatic logic state_is_init(routing_state_t s);
        return s inside {I_GENERATE_PARENT_REQUEST, I_WAIT_PARENT_ACK,
                         I_GENERATE_JOIN_REQUEST, I_WAIT_JOIN_ACK};
    endfunction

endpackage

// File: rtl/routing_timeout_timer.sv
// rtl/routing_timeout_timer.sv - loadable down-counter flagging expiry at zero
module routing_timeout_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/routing_join_controller.sv
// rtl/routing_join_controller.sv - network-join handshake sequencer; heartbeat emission under ROUTING_HEARTBEAT_EN
module routing_join_controller
    import system_types::*;
#(
    parameter int TIMEOUT_CYCLES   = ROUTING_DEFAULT_TIMEOUT,
    parameter int MAX_RETRY        = ROUTING_DEFAULT_MAX_RETRY,
    parameter int HEARTBEAT_PERIOD = ROUTING_DEFAULT_HEARTBEAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        separate,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_header,
    output logic [63:0] tx_payload,
    input  logic        rx_valid,
    input  logic [7:0]  rx_header,
    input  logic [63:0] rx_payload,
    output logic [3:0]  state,
    output logic [7:0]  node_id,
    output logic [7:0]  parent_id,
    output logic        joined,
    output logic        fatal
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 1);

    routing_state_t state_q, state_d;
    logic [RW-1:0]  retry_q;
    node_id_t       cap_parent_q, cap_child_q, node_id_q, parent_id_q;

    logic          tmr_load, tmr_enable, tmr_expired;
    logic [TW-1:0] tmr_value;
    logic          retry_clr, retry_inc, capture, commit;

    parent_ack_t rx_pack;
    join_ack_t   rx_jack;
    logic        rx_unused;
    logic        path_init, rx_reset, pack_match, jack_match, tx_fire, retries_spent;

    assign rx_pack   = parent_ack_t'(rx_payload);
    assign rx_jack   = join_ack_t'(rx_payload);
    assign rx_unused = ^{rx_pack.rsvd, rx_jack.rsvd, rx_jack.cur_id};

    assign path_init  = state_is_init(state_q);
    assign rx_reset   = rx_valid && (rx_header == S_RESET);
    assign pack_match = rx_valid && (rx_header == S_PARENT_ACK) && (rx_pack.is_init == path_init);
    assign jack_match = rx_valid && (rx_header == S_JOIN_ACK) && (rx_jack.is_init == path_init)
                        && (rx_jack.parent_id == cap_parent_q) && (rx_jack.child_id == cap_child_q);
    assign tx_fire       = tx_valid && tx_ready;
    assign retries_spent = (retry_q == RW'(MAX_RETRY));

    routing_timeout_timer #(.WIDTH(TW)) u_ack_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .enable     (tmr_enable),
        .expired    (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_value  = TW'(TIMEOUT_CYCLES - 1);
        tmr_enable = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        if (rx_reset) begin
            state_d   = INIT;
            tmr_load  = 1'b1;
            tmr_value = '0;
            retry_clr = 1'b1;
        end else begin
            case (state_q)
                INIT: if (start) begin
                    state_d   = I_GENERATE_PARENT_REQUEST;
                    retry_clr = 1'b1;
                end
                I_GENERATE_PARENT_REQUEST, S_GENERATE_PARENT_REQUEST: if (tx_fire) begin
                    state_d   = path_init ? I_WAIT_PARENT_ACK : S_WAIT_PARENT_ACK;
                    tmr_load  = 1'b1;
                    retry_inc = 1'b1;
                end
                I_GENERATE_JOIN_REQUEST, S_GENERATE_JOIN_REQUEST: if (tx_fire) begin
                    state_d  = path_init ? I_WAIT_JOIN_ACK : S_WAIT_JOIN_ACK;
                    tmr_load = 1'b1;
                end
                I_WAIT_PARENT_ACK, S_WAIT_PARENT_ACK, I_WAIT_JOIN_ACK, S_WAIT_JOIN_ACK: begin
                    tmr_enable = 1'b1;
                    // An ack arriving on the expiry cycle still counts.
                    if (pack_match && (state_q == I_WAIT_PARENT_ACK || state_q == S_WAIT_PARENT_ACK)) begin
                        state_d = path_init ? I_GENERATE_JOIN_REQUEST : S_GENERATE_JOIN_REQUEST;
                        capture = 1'b1;
                    end else if (jack_match && (state_q == I_WAIT_JOIN_ACK || state_q == S_WAIT_JOIN_ACK)) begin
                        state_d = NORMAL;
                        commit  = 1'b1;
                    end else if (tmr_expired) begin
                        state_d = retries_spent ? FATAL_ERROR
                                : (path_init ? I_GENERATE_PARENT_REQUEST : S_GENERATE_PARENT_REQUEST);
                    end
                end
                NORMAL: if (separate) begin
                    state_d   = S_GENERATE_PARENT_REQUEST;
                    retry_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q      <= '0;
            cap_parent_q <= '0;
            cap_child_q  <= '0;
            node_id_q    <= '0;
            parent_id_q  <= '0;
        end else begin
            if (retry_clr)                         retry_q <= '0;
            else if (retry_inc && !retries_spent)  retry_q <= retry_q + 1'b1;
            if (rx_reset) begin
                cap_parent_q <= '0;
                cap_child_q  <= '0;
                node_id_q    <= '0;
                parent_id_q  <= '0;
            end else begin
                if (capture) begin
                    cap_parent_q <= rx_pack.parent_id;
                    cap_child_q  <= rx_pack.child_id;
                end
                if (commit) begin
                    node_id_q   <= cap_child_q;
                    parent_id_q <= cap_parent_q;
                end
            end
        end
    end

`ifdef ROUTING_HEARTBEAT_EN
    localparam int HW = (HEARTBEAT_PERIOD > 2) ? $clog2(HEARTBEAT_PERIOD) : 1;
    logic in_normal, hb_expired, hb_pending;
    assign in_normal = (state_q == NORMAL);

    // The period timer reloads on NORMAL entry and on every expiry, so beats stay periodic.
    routing_timeout_timer #(.WIDTH(HW)) u_hb_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (commit || (in_normal && hb_expired)),
        .load_value (HW'(HEARTBEAT_PERIOD - 1)),
        .enable     (in_normal),
        .expired    (hb_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  hb_pending <= 1'b0;
        else if (rx_reset || !in_normal || separate) hb_pending <= 1'b0;
        else if (hb_expired)                         hb_pending <= 1'b1;
        else if (tx_fire)                            hb_pending <= 1'b0;
    end
`else
    localparam int hb_period_unused = HEARTBEAT_PERIOD;
`endif

    always_comb begin
        tx_valid   = 1'b0;
        tx_header  = S_NONE;
        tx_payload = '0;
        case (state_q)
            I_GENERATE_PARENT_REQUEST, S_GENERATE_PARENT_REQUEST: begin
                tx_valid   = 1'b1;
                tx_header  = S_PARENT_REQUEST;
                tx_payload = parent_request_t'{rsvd: '0, is_init: path_init};
            end
            I_GENERATE_JOIN_REQUEST, S_GENERATE_JOIN_REQUEST: begin
                tx_valid   = 1'b1;
                tx_header  = S_JOIN_REQUEST;
                tx_payload = join_request_t'{rsvd: '0, is_init: path_init,
                                             parent_id: cap_parent_q, child_id: cap_child_q};
            end
`ifdef ROUTING_HEARTBEAT_EN
            NORMAL: if (hb_pending) begin
                tx_valid  = 1'b1;
                tx_header = S_HEARTBEAT;
            end
`endif
            default: ;
        endcase
    end

    assign state     = state_q;
    assign node_id   = node_id_q;
    assign parent_id = parent_id_q;
    assign joined    = (state_q == NORMAL);
    assign fatal     = (state_q == FATAL_ERROR);

endmodule

// File: tb/tb_routing_join_controller.sv
// tb/tb_routing_join_controller.sv - directed self-checking bench for routing_join_controller
module tb_routing_join_controller;

    localparam logic [3:0] ST_INIT = 4'd0, ST_I_GPR = 4'd1, ST_I_WPA = 4'd2, ST_I_GJR = 4'd3,
                           ST_I_WJA = 4'd4, ST_S_GPR = 4'd5, ST_S_WPA = 4'd6,
                           ST_NORMAL = 4'd9, ST_FATAL = 4'd10;
    localparam logic [7:0] H_PREQ = 8'h01, H_PACK = 8'h02, H_JREQ = 8'h03,
                           H_JACK = 8'h04, H_RESET = 8'h05, H_HB = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n, start, separate, tx_valid, tx_ready, rx_valid, joined, fatal;
    logic [7:0]  tx_header, rx_header, node_id, parent_id;
    logic [63:0] tx_payload, rx_payload;
    logic [3:0]  state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    routing_join_controller #(
        .TIMEOUT_CYCLES   (16),
        .MAX_RETRY        (3),
        .HEARTBEAT_PERIOD (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .separate   (separate),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_header  (tx_header),
        .tx_payload (tx_payload),
        .rx_valid   (rx_valid),
        .rx_header  (rx_header),
        .rx_payload (rx_payload),
        .state      (state),
        .node_id    (node_id),
        .parent_id  (parent_id),
        .joined     (joined),
        .fatal      (fatal)
    );

    function automatic logic [63:0] pack_pl(input logic init, input logic [7:0] p, input logic [7:0] c);
        return {47'b0, init, p, c};
    endfunction

    function automatic logic [63:0] jack_pl(input logic init, input logic [7:0] cur,
                                            input logic [7:0] p, input logic [7:0] c);
        return {39'b0, init, cur, p, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] h, input logic [63:0] p);
        rx_valid   = 1'b1;
        rx_header  = h;
        rx_payload = p;
        tick();
        rx_valid   = 1'b0;
        rx_header  = 8'h00;
        rx_payload = 64'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; separate = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_header = 8'h00; rx_payload = 64'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; separate = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_header = 8'h00; rx_payload = 64'h0;
        tick();
        tick();
        checks++; if (state !== ST_INIT) begin failures++; $display("FAIL reset_state got=%0h exp=%0h", state, ST_INIT); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (node_id !== 8'h00 || parent_id !== 8'h00) begin failures++; $display("FAIL reset_ids got=%0h/%0h exp=0/0", node_id, parent_id); end
        checks++; if (joined !== 1'b0 || fatal !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", joined, fatal); end
        rst_n = 1'b1;
        tick();
        checks++; if (state !== ST_INIT) begin failures++; $display("FAIL idle_state got=%0h exp=%0h", state, ST_INIT); end
    endtask

    task automatic test_happy_path();
        tx_ready = 1'b1;
        pulse_start();
        checks++; if (state !== ST_I_GPR || tx_valid !== 1'b1) begin failures++; $display("FAIL hp_gen_pr got=%0h/%0b exp=%0h/1", state, tx_valid, ST_I_GPR); end
        checks++; if (tx_header !== H_PREQ || tx_payload !== 64'h1) begin failures++; $display("FAIL hp_preq_msg got=%0h/%0h exp=%0h/1", tx_header, tx_payload, H_PREQ); end
        tick();
        checks++; if (state !== ST_I_WPA || tx_valid !== 1'b0) begin failures++; $display("FAIL hp_wait_pa got=%0h/%0b exp=%0h/0", state, tx_valid, ST_I_WPA); end
        repeat (9) tick();
        send_rx(H_PACK, pack_pl(1'b1, 8'h05, 8'h12));
        checks++; if (state !== ST_I_GJR || tx_header !== H_JREQ) begin failures++; $display("FAIL hp_gen_jr got=%0h/%0h exp=%0h/%0h", state, tx_header, ST_I_GJR, H_JREQ); end
        checks++; if (tx_payload !== 64'h0000_0000_0001_0512) begin failures++; $display("FAIL hp_jreq_payload got=%0h exp=10512", tx_payload); end
        tick();
        checks++; if (state !== ST_I_WJA) begin failures++; $display("FAIL hp_wait_ja got=%0h exp=%0h", state, ST_I_WJA); end
        send_rx(H_JACK, jack_pl(1'b1, 8'h00, 8'h05, 8'h12));
        checks++; if (state !== ST_NORMAL || joined !== 1'b1) begin failures++; $display("FAIL hp_normal got=%0h/%0b exp=%0h/1", state, joined, ST_NORMAL); end
        checks++; if (node_id !== 8'h12 || parent_id !== 8'h05) begin failures++; $display("FAIL hp_ids got=%0h/%0h exp=12/05", node_id, parent_id); end
    endtask

    task automatic test_heartbeat();
        int beats = 0;
        int bad_hdr = 0;
        int exp_beats;
`ifdef ROUTING_HEARTBEAT_EN
        exp_beats = 2;
`else
        exp_beats = 0;
`endif
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid) begin
                beats++;
                if (tx_header !== H_HB || tx_payload !== 64'h0) bad_hdr++;
            end
        end
        checks++; if (beats != exp_beats) begin failures++; $display("FAIL hb_count got=%0d exp=%0d", beats, exp_beats); end
        checks++; if (bad_hdr != 0) begin failures++; $display("FAIL hb_msg got=%0d bad exp=0", bad_hdr); end
    endtask

    task automatic test_separation_and_reset();
        separate = 1'b1;
        tick();
        separate = 1'b0;
        checks++; if (state !== ST_S_GPR || tx_header !== H_PREQ || tx_payload !== 64'h0) begin failures++; $display("FAIL sep_preq got=%0h/%0h/%0h exp=%0h/%0h/0", state, tx_header, tx_payload, ST_S_GPR, H_PREQ); end
        checks++; if (node_id !== 8'h12 || joined !== 1'b0) begin failures++; $display("FAIL sep_node got=%0h/%0b exp=12/0", node_id, joined); end
        tick();
        checks++; if (state !== ST_S_WPA) begin failures++; $display("FAIL sep_wait got=%0h exp=%0h", state, ST_S_WPA); end
        tick();
        tick();
        send_rx(H_RESET, 64'h0);
        checks++; if (state !== ST_INIT || tx_valid !== 1'b0) begin failures++; $display("FAIL rst_msg_state got=%0h/%0b exp=%0h/0", state, tx_valid, ST_INIT); end
        checks++; if (node_id !== 8'h00 || parent_id !== 8'h00) begin failures++; $display("FAIL rst_msg_ids got=%0h/%0h exp=0/0", node_id, parent_id); end
    endtask

    task automatic test_mismatch_join_ack();
        tx_ready = 1'b1;
        pulse_start();
        tick();
        send_rx(H_PACK, pack_pl(1'b0, 8'h05, 8'h12));
        checks++; if (state !== ST_I_WPA) begin failures++; $display("FAIL mm_pack_init got=%0h exp=%0h", state, ST_I_WPA); end
        send_rx(H_PACK, pack_pl(1'b1, 8'h05, 8'h12));
        tick();
        send_rx(H_JACK, jack_pl(1'b1, 8'h00, 8'h05, 8'h13));
        checks++; if (state !== ST_I_WJA || joined !== 1'b0) begin failures++; $display("FAIL mm_jack_ignored got=%0h/%0b exp=%0h/0", state, joined, ST_I_WJA); end
        send_rx(H_JACK, jack_pl(1'b1, 8'h00, 8'h05, 8'h12));
        checks++; if (state !== ST_NORMAL || node_id !== 8'h12) begin failures++; $display("FAIL mm_jack_ok got=%0h/%0h exp=%0h/12", state, node_id, ST_NORMAL); end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        do_reset();
        tx_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            tick();
            if ({state, tx_valid, tx_header, tx_payload} !== {ST_I_GPR, 1'b1, H_PREQ, 64'h1}) held_bad++;
        end
        checks++; if (held_bad != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable exp=0", held_bad); end
        tx_ready = 1'b1;
        tick();
        checks++; if (state !== ST_I_WPA || tx_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%0h/%0b exp=%0h/0", state, tx_valid, ST_I_WPA); end
    endtask

    task automatic test_ack_on_expiry();
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        tick();
        repeat (15) tick();
        checks++; if (state !== ST_I_WPA) begin failures++; $display("FAIL exp_still_wait got=%0h exp=%0h", state, ST_I_WPA); end
        send_rx(H_PACK, pack_pl(1'b1, 8'h07, 8'h21));
        checks++; if (state !== ST_I_GJR || tx_payload !== 64'h0000_0000_0001_0721) begin failures++; $display("FAIL exp_match_wins got=%0h/%0h exp=%0h/10721", state, tx_payload, ST_I_GJR); end
    endtask

    task automatic test_timeout_fatal();
        int nreq = 0;
        int req_at[3] = '{-1, -1, -1};
        int fatal_at = -1;
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 80; i++) begin
            if (tx_valid && tx_header == H_PREQ) begin
                if (nreq < 3) req_at[nreq] = i;
                nreq++;
            end
            if (fatal && fatal_at < 0) fatal_at = i;
            tick();
        end
        checks++; if (nreq != 3) begin failures++; $display("FAIL to_req_count got=%0d exp=3", nreq); end
        checks++; if (req_at[1] - req_at[0] != 17 || req_at[2] - req_at[1] != 17) begin failures++; $display("FAIL to_req_spacing got=%0d,%0d,%0d exp=0,17,34", req_at[0], req_at[1], req_at[2]); end
        checks++; if (fatal_at != 51) begin failures++; $display("FAIL to_fatal_cycle got=%0d exp=51", fatal_at); end
        pulse_start();
        separate = 1'b1;
        tick();
        separate = 1'b0;
        repeat (10) tick();
        checks++; if (fatal !== 1'b1 || state !== ST_FATAL || tx_valid !== 1'b0) begin failures++; $display("FAIL to_sticky got=%0b/%0h/%0b exp=1/%0h/0", fatal, state, tx_valid, ST_FATAL); end
        send_rx(H_RESET, 64'h0);
        checks++; if (state !== ST_INIT || fatal !== 1'b0) begin failures++; $display("FAIL to_reset_exit got=%0h/%0b exp=%0h/0", state, fatal, ST_INIT); end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_heartbeat();
        test_separation_and_reset();
        test_mismatch_join_ack();
        test_backpressure();
        test_ack_on_expiry();
        test_timeout_fatal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
